// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin sharing of one SPI byte engine between requesters,
// with per-slave chip select, setup/hold/gap sequencing and a per-byte timeout.
module spi_xfer_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_LEN   = 16,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2,
    parameter int GAP_CYC   = 4,
    parameter int TIMEOUT   = 1024,
    localparam int LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*LEN_W-1:0] i_req_len,
    input  logic [NUM_REQ*8-1:0]     i_req_tx,
    output logic [NUM_REQ-1:0]       o_req_tx_ack,
    output logic [7:0]               o_rx_data,
    output logic [NUM_REQ-1:0]       o_rx_valid,
    output logic [NUM_REQ-1:0]       o_done,
    output logic [NUM_REQ-1:0]       o_err,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic [NUM_REQ-1:0]       o_cs_n,
    output logic                     o_eng_start,
    output logic [7:0]               o_eng_tx,
    input  logic                     i_eng_busy,
    input  logic                     i_eng_done,
    input  logic [7:0]               i_eng_rx
);
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (SETUP_CYC > HOLD_CYC) ? ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC)
                                                    : ((HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMR_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LAUNCH, S_WAIT, S_HOLD, S_GAP} state_t;

    state_t               r_state, w_state;
    logic [IDX_W-1:0]     r_ptr, w_ptr, r_idx, w_idx, w_win;
    logic [LEN_W-1:0]     r_rem, w_rem, w_win_raw, w_win_len;
    logic [CNT_W-1:0]     r_cnt, w_cnt;
    logic [TMR_W-1:0]     r_tmr, w_tmr;
    logic [NUM_REQ-1:0]   r_grant, w_grant, r_cs_n, w_cs_n;
    logic [NUM_REQ-1:0]   r_rx_valid, w_rx_valid, r_done, w_done, r_err, w_err;
    logic [NUM_REQ-1:0]   w_oh, w_win_oh;
    logic [7:0]           r_rx_data, w_rx_data, w_tx;
    logic                 w_found;

    function automatic logic [IDX_W-1:0] wrap(input int v);
        return IDX_W'((v >= NUM_REQ) ? v - NUM_REQ : v);
    endfunction

    // Descending scan so the lowest offset from the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[wrap(int'(r_ptr) + k)]) begin
                w_found = 1'b1;
                w_win   = wrap(int'(r_ptr) + k);
            end
        end
    end

    always_comb begin
        w_win_raw = '0;
        w_tx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDX_W'(k) == w_win) w_win_raw = i_req_len[k*LEN_W +: LEN_W];
            if (IDX_W'(k) == r_idx) w_tx = i_req_tx[k*8 +: 8];
        end
        w_win_len = (w_win_raw > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : w_win_raw;
        w_oh      = NUM_REQ'(1) << r_idx;
        w_win_oh  = NUM_REQ'(1) << w_win;
    end

    always_comb begin
        w_state      = r_state;
        w_ptr        = r_ptr;
        w_idx        = r_idx;
        w_rem        = r_rem;
        w_cnt        = r_cnt;
        w_tmr        = r_tmr;
        w_grant      = r_grant;
        w_cs_n       = r_cs_n;
        w_rx_data    = r_rx_data;
        w_rx_valid   = '0;
        w_done       = '0;
        w_err        = '0;
        o_eng_start  = 1'b0;
        o_eng_tx     = '0;
        o_req_tx_ack = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_idx = w_win;
                    w_ptr = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
                    w_rem = w_win_len;
                    w_cnt = '0;
                    if (w_win_len == '0) begin
                        w_done  = w_win_oh;
                        w_state = S_GAP;
                    end else begin
                        w_grant = w_win_oh;
                        w_cs_n  = ~w_win_oh;
                        w_state = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                w_cnt   = (r_cnt == CNT_W'(SETUP_CYC - 1)) ? '0 : r_cnt + 1'b1;
                w_state = (r_cnt == CNT_W'(SETUP_CYC - 1)) ? S_LAUNCH : S_SETUP;
            end
            S_LAUNCH: begin
                if (!i_eng_busy) begin
                    o_eng_start  = 1'b1;
                    o_eng_tx     = w_tx;
                    o_req_tx_ack = w_oh;
                    w_tmr        = '0;
                    w_state      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_eng_done) begin
                    w_rx_data  = i_eng_rx;
                    w_rx_valid = w_oh;
                    w_rem      = r_rem - 1'b1;
                    w_cnt      = '0;
                    w_state    = (r_rem == LEN_W'(1)) ? S_HOLD : S_LAUNCH;
                end else if (r_tmr == TMR_W'(TIMEOUT - 1)) begin
                    w_err   = w_oh;
                    w_cs_n  = '1;
                    w_grant = '0;
                    w_cnt   = '0;
                    w_state = S_GAP;
                end else begin
                    w_tmr = r_tmr + 1'b1;
                end
            end
            S_HOLD: begin
                if (r_cnt == CNT_W'(HOLD_CYC - 1)) begin
                    w_cs_n  = '1;
                    w_grant = '0;
                    w_done  = w_oh;
                    w_cnt   = '0;
                    w_state = S_GAP;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                w_cnt   = (r_cnt == CNT_W'(GAP_CYC - 1)) ? '0 : r_cnt + 1'b1;
                w_state = (r_cnt == CNT_W'(GAP_CYC - 1)) ? S_IDLE : S_GAP;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_idx      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_tmr      <= '0;
            r_grant    <= '0;
            r_cs_n     <= '1;
            r_rx_data  <= '0;
            r_rx_valid <= '0;
            r_done     <= '0;
            r_err      <= '0;
        end else begin
            r_state    <= w_state;
            r_ptr      <= w_ptr;
            r_idx      <= w_idx;
            r_rem      <= w_rem;
            r_cnt      <= w_cnt;
            r_tmr      <= w_tmr;
            r_grant    <= w_grant;
            r_cs_n     <= w_cs_n;
            r_rx_data  <= w_rx_data;
            r_rx_valid <= w_rx_valid;
            r_done     <= w_done;
            r_err      <= w_err;
        end
    end

    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_grant    = r_grant;
    assign o_cs_n     = r_cs_n;
endmodule
